pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It generates write-enable, hold, flush and bubble controls for the PC and for the IF/ID, ID/EX and EX/MEM pipeline registers. It covers three cases: load-use stalls, taken-branch flushes, and fixed-latency multicycle EX operations (multiply/divide). It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register-file address width
MC_LATENCY, 4, total EX occupancy in cycles of a multicycle op including its start cycle; legal range 2..16
CNT_W, 16, width of StallCount

Ports:
Clock  in  1  pipeline clock; all state updates on posedge
Reset  in  1  asynchronous, active-high reset
IDRs  in  REG_ADDR_W  rs of the instruction in ID
IDRt  in  REG_ADDR_W  rt of the instruction in ID
IDUsesRs  in  1  ID instruction reads rs
IDUsesRt  in  1  ID instruction reads rt
EXMemRead  in  1  instruction in EX is a load
EXRegWrite  in  1  instruction in EX writes the register file
EXWriteRegister  in  REG_ADDR_W  destination register of the EX instruction
EXBranchTaken  in  1  branch resolved taken in EX this cycle
MCStart  in  1  multicycle op entered EX this cycle
PCWrite  out  1  PC load enable
IFIDWrite  out  1  IF/ID load enable
IFIDFlush  out  1  clear IF/ID to NOP
IDEXFlush  out  1  load a bubble into ID/EX
IDEXHold  out  1  ID/EX retains its contents
EXMEMBubble  out  1  EX/MEM captures RegWrite=0
MCBusy  out  1  multicycle op in progress
MCDone  out  1  final cycle of the multicycle op; EX result valid
StallCount  out  CNT_W  saturating count of cycles with PCWrite=0

Behaviour:
- Reset asserted, asynchronous and overriding everything:
  - PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, IDEXHold=0, EXMEMBubble=0, MCBusy=0, MCDone=0.
  - StallCount=0, state=RUN, mc_cnt=0.
  - A reset during MC_BUSY abandons the op; there is no completion pulse.
- States: RUN, MC_BUSY. Control outputs are combinational from the state and inputs. State, mc_cnt and StallCount are registered.
- load_use = EXMemRead & EXRegWrite & (EXWriteRegister!=0) & ((IDUsesRs & IDRs==EXWriteRegister) | (IDUsesRt & IDRt==EXWriteRegister)).
- RUN defaults: PCWrite=1, IFIDWrite=1, all flush/hold/bubble signals 0, MCBusy=0, MCDone=0.
- RUN priority, highest first:
  1. MCStart: PCWrite=0, IFIDWrite=0, IDEXHold=1, EXMEMBubble=1, MCBusy=1. Next state MC_BUSY, mc_cnt=MC_LATENCY-2.
  2. EXBranchTaken: IFIDFlush=1, IDEXFlush=1, PCWrite=1 so the branch target loads. Any coincident load_use is discarded because the ID instruction is squashed.
  3. load_use: PCWrite=0, IFIDWrite=0, IDEXFlush=1. Exactly one bubble; next cycle the load is in MEM and is forwarded normally. Stay in RUN.
- MC_BUSY with mc_cnt!=0:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXHold=1, EXMEMBubble=1, MCBusy=1.
  - mc_cnt decrements each cycle.
  - EXBranchTaken, MCStart and load_use are ignored.
- MC_BUSY with mc_cnt==0:
  - Outputs: PCWrite=1, IFIDWrite=1, IDEXHold=0, EXMEMBubble=0, MCBusy=1, MCDone=1.
  - EX/MEM captures the result at this edge; next state RUN.
- Total stall: MC_LATENCY-1 cycles with PCWrite=0 per multicycle op. With MC_LATENCY=2, MC_BUSY lasts exactly one cycle, with mc_cnt==0.
- MCStart while leaving MC_BUSY is not possible, since the next instruction reaches EX one cycle later; it is handled by RUN on that later cycle.
- StallCount: increments at every posedge where PCWrite==0 and Reset==0; holds at 2^CNT_W-1 with no wrap.
- A zero destination register never triggers load_use.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - state enum typedef {RUN, MC_BUSY};
  - REG_ZERO constant;
  - REG_ADDR_W default shared with the register file and pipeline registers.
- One natural sub-module: load_use_detect, the purely combinational comparator producing load_use. The FSM, counter and StallCount stay in the top.

Test Plan:
- Reset pulse of 3 cycles mid-stream -> all outputs at reset values during reset; first cycle after reset PCWrite=1, IFIDWrite=1, StallCount=0.
- EX lw $t1 (EXWriteRegister=9, EXMemRead=1, EXRegWrite=1), ID add with IDRs=9, IDUsesRs=1 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; StallCount 0->1; next cycle normal.
- Same as the previous case but EXWriteRegister=0 -> no stall; also with IDUsesRs=0 -> no stall.
- EXBranchTaken=1 coincident with a load_use match -> IFIDFlush=1, IDEXFlush=1, PCWrite=1; StallCount unchanged.
- MCStart=1, MC_LATENCY=4 -> PCWrite=0 for 3 cycles; MCDone=1 only on the 4th cycle; MCBusy=1 for 4 cycles; EXMEMBubble=1 for the first 3; StallCount +3; EXBranchTaken pulsed mid-op is ignored.
- Force StallCount near 2^CNT_W-1 (CNT_W=4: 15 stalls, then 2 more) -> counter holds at 15. Reset asserted in cycle 2 of an MC op -> immediate return to reset values with no MCDone.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    // Register-file address width shared with the register file and pipeline registers
    localparam int REG_ADDR_W_DFLT = 5;

    // Architectural zero register; writes to it are discarded, so it never creates a hazard
    localparam int REG_ZERO = 0;

    // Controller sequencing states
    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result feeds the stall controller directly.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_write_register,
    output logic                  load_use
);

    logic dst_live;
    logic rs_hit;
    logic rt_hit;

    // A load to the zero register produces nothing to wait for
    always_comb begin
        dst_live = ex_mem_read & ex_reg_write &
                   (ex_write_register != REG_ADDR_W'(REG_ZERO));
        rs_hit   = id_uses_rs & (id_rs == ex_write_register);
        rt_hit   = id_uses_rt & (id_rt == ex_write_register);
        load_use = dst_live & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard/sequencing control for PC, IF/ID, ID/EX, EX/MEM plus a saturating stall counter.
// Latency: controls are combinational from state and inputs; state updates on posedge Clock.
// Backpressure: stalls the front end (PCWrite/IFIDWrite low) on load-use and while a multicycle op occupies EX.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] IDRs,
    input  logic [REG_ADDR_W-1:0] IDRt,
    input  logic                  IDUsesRs,
    input  logic                  IDUsesRt,
    input  logic                  EXMemRead,
    input  logic                  EXRegWrite,
    input  logic [REG_ADDR_W-1:0] EXWriteRegister,
    input  logic                  EXBranchTaken,
    input  logic                  MCStart,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IFIDFlush,
    output logic                  IDEXFlush,
    output logic                  IDEXHold,
    output logic                  EXMEMBubble,
    output logic                  MCBusy,
    output logic                  MCDone,
    output logic [CNT_W-1:0]      StallCount
);

    // Counter holds up to MC_LATENCY-2 (at most 14 for the legal range)
    localparam int MC_CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

    state_t              state, state_nxt;
    logic [MC_CNT_W-1:0] mc_cnt, mc_cnt_nxt;
    logic                load_use;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs             (IDRs),
        .id_rt             (IDRt),
        .id_uses_rs        (IDUsesRs),
        .id_uses_rt        (IDUsesRt),
        .ex_mem_read       (EXMemRead),
        .ex_reg_write      (EXRegWrite),
        .ex_write_register (EXWriteRegister),
        .load_use          (load_use)
    );

    // Next-state and control outputs; reset forces the flush-everything, load-nothing pattern
    always_comb begin
        state_nxt   = state;
        mc_cnt_nxt  = mc_cnt;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        IDEXHold    = 1'b0;
        EXMEMBubble = 1'b0;
        MCBusy      = 1'b0;
        MCDone      = 1'b0;
        if (Reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (MCStart) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXHold    = 1'b1;
                        EXMEMBubble = 1'b1;
                        MCBusy      = 1'b1;
                        state_nxt   = MC_BUSY;
                        mc_cnt_nxt  = MC_CNT_W'(MC_LATENCY - 2);
                    end else if (EXBranchTaken) begin
                        // ID instruction is squashed, so any load-use against it is moot
                        IFIDFlush = 1'b1;
                        IDEXFlush = 1'b1;
                    end else if (load_use) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                    end
                end
                MC_BUSY: begin
                    MCBusy = 1'b1;
                    if (mc_cnt != '0) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXHold    = 1'b1;
                        EXMEMBubble = 1'b1;
                        mc_cnt_nxt  = mc_cnt - 1'b1;
                    end else begin
                        // Final cycle: EX/MEM captures the result and the front end resumes
                        MCDone    = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State, multicycle countdown and saturating stall counter
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= RUN;
            mc_cnt     <= '0;
            StallCount <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
            if (!PCWrite && (StallCount != '1)) begin
                StallCount <= StallCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with two instances sharing stimulus.
// dut: MC_LATENCY=4, CNT_W=4; dut2: MC_LATENCY=2, CNT_W=16.
// Inputs change and outputs are sampled around the negative clock edge.
module tb_pipeline_stall_controller;

    logic       Clock;
    logic       Reset;
    logic [4:0] IDRs, IDRt, EXWriteRegister;
    logic       IDUsesRs, IDUsesRt, EXMemRead, EXRegWrite, EXBranchTaken, MCStart;

    logic        pc_w1, ifid_w1, ifid_f1, idex_f1, idex_h1, exmem_b1, busy1, done1;
    logic        pc_w2, ifid_w2, ifid_f2, idex_f2, idex_h2, exmem_b2, busy2, done2;
    logic [3:0]  cnt1;
    logic [15:0] cnt2;
    logic [7:0]  ctl1, ctl2;

    int checks = 0;
    int errors = 0;

    // {PCWrite,IFIDWrite,IFIDFlush,IDEXFlush,IDEXHold,EXMEMBubble,MCBusy,MCDone}
    localparam logic [7:0] C_RST  = 8'b0011_0000;
    localparam logic [7:0] C_NORM = 8'b1100_0000;
    localparam logic [7:0] C_LU   = 8'b0001_0000;
    localparam logic [7:0] C_BR   = 8'b1111_0000;
    localparam logic [7:0] C_BUSY = 8'b0000_1110;
    localparam logic [7:0] C_DONE = 8'b1100_0011;

    pipeline_stall_controller #(.REG_ADDR_W(5), .MC_LATENCY(4), .CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .IDRs(IDRs), .IDRt(IDRt),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead),
        .EXRegWrite(EXRegWrite), .EXWriteRegister(EXWriteRegister),
        .EXBranchTaken(EXBranchTaken), .MCStart(MCStart),
        .PCWrite(pc_w1), .IFIDWrite(ifid_w1), .IFIDFlush(ifid_f1), .IDEXFlush(idex_f1),
        .IDEXHold(idex_h1), .EXMEMBubble(exmem_b1), .MCBusy(busy1), .MCDone(done1),
        .StallCount(cnt1)
    );

    pipeline_stall_controller #(.REG_ADDR_W(5), .MC_LATENCY(2), .CNT_W(16)) dut2 (
        .Clock(Clock), .Reset(Reset), .IDRs(IDRs), .IDRt(IDRt),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead),
        .EXRegWrite(EXRegWrite), .EXWriteRegister(EXWriteRegister),
        .EXBranchTaken(EXBranchTaken), .MCStart(MCStart),
        .PCWrite(pc_w2), .IFIDWrite(ifid_w2), .IFIDFlush(ifid_f2), .IDEXFlush(idex_f2),
        .IDEXHold(idex_h2), .EXMEMBubble(exmem_b2), .MCBusy(busy2), .MCDone(done2),
        .StallCount(cnt2)
    );

    assign ctl1 = {pc_w1, ifid_w1, ifid_f1, idex_f1, idex_h1, exmem_b1, busy1, done1};
    assign ctl2 = {pc_w2, ifid_w2, ifid_f2, idex_f2, idex_h2, exmem_b2, busy2, done2};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic idle_inputs();
        IDRs = 5'd0; IDRt = 5'd0; IDUsesRs = 1'b0; IDUsesRt = 1'b0;
        EXMemRead = 1'b0; EXRegWrite = 1'b0; EXWriteRegister = 5'd0;
        EXBranchTaken = 1'b0; MCStart = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] dst);
        EXMemRead = 1'b1; EXRegWrite = 1'b1; EXWriteRegister = dst;
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();

        // Initial reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock); #1;
            chk("rst_ctl", ctl1, C_RST);
            chk("rst_ctl2", ctl2, C_RST);
            chk("rst_cnt", cnt1, 0);
        end
        Reset = 1'b0; #1;
        chk("post_rst_ctl", ctl1, C_NORM);
        chk("post_rst_cnt", cnt1, 0);
        tick(); #1;
        chk("idle_cnt", cnt1, 0);

        // Load-use through rs: exactly one bubble
        set_load(5'd9); IDRs = 5'd9; IDUsesRs = 1'b1; #1;
        chk("lu_rs_ctl", ctl1, C_LU);
        chk("lu_rs_ctl2", ctl2, C_LU);
        tick(); idle_inputs(); #1;
        chk("lu_rs_after", ctl1, C_NORM);
        chk("lu_rs_cnt", cnt1, 1);

        // Load-use through rt
        set_load(5'd12); IDRt = 5'd12; IDUsesRt = 1'b1; IDRs = 5'd12; #1;
        chk("lu_rt_ctl", ctl1, C_LU);
        tick(); idle_inputs(); #1;
        chk("lu_rt_cnt", cnt1, 2);

        // Zero destination never stalls
        set_load(5'd0); IDRs = 5'd0; IDUsesRs = 1'b1; #1;
        chk("lu_zero_ctl", ctl1, C_NORM);
        tick(); idle_inputs();
        // Matching register but rs not read
        set_load(5'd9); IDRs = 5'd9; IDUsesRs = 1'b0; IDRt = 5'd3; IDUsesRt = 1'b1; #1;
        chk("lu_unused_ctl", ctl1, C_NORM);
        tick(); idle_inputs(); #1;
        chk("no_stall_cnt", cnt1, 2);

        // Taken branch wins over a coincident load-use
        set_load(5'd9); IDRs = 5'd9; IDUsesRs = 1'b1; EXBranchTaken = 1'b1; #1;
        chk("br_ctl", ctl1, C_BR);
        tick(); idle_inputs(); #1;
        chk("br_cnt", cnt1, 2);
        chk("br_cnt2", cnt2, 2);

        // Multicycle op: dut 4 cycles, dut2 2 cycles; mid-op branch ignored
        MCStart = 1'b1; #1;
        chk("mc_c0", ctl1, C_BUSY);
        chk("mc2_c0", ctl2, C_BUSY);
        tick(); MCStart = 1'b0; EXBranchTaken = 1'b1; #1;
        chk("mc_c1_br", ctl1, C_BUSY);
        chk("mc2_c1_done", ctl2, C_DONE);
        tick(); EXBranchTaken = 1'b0; #1;
        chk("mc_c2", ctl1, C_BUSY);
        chk("mc2_c2", ctl2, C_NORM);
        tick(); #1;
        chk("mc_c3_done", ctl1, C_DONE);
        tick(); #1;
        chk("mc_after", ctl1, C_NORM);
        chk("mc_cnt", cnt1, 5);
        chk("mc_cnt2", cnt2, 3);

        // Mid-stream reset pulse of three cycles
        Reset = 1'b1; #1;
        chk("mid_rst_ctl", ctl1, C_RST);
        chk("mid_rst_cnt", cnt1, 0);
        tick(); tick(); tick();
        Reset = 1'b0; #1;
        chk("mid_post_ctl", ctl1, C_NORM);

        // Saturation: 15 stalls then 2 more
        set_load(5'd7); IDRs = 5'd7; IDUsesRs = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        #1;
        chk("sat_15", cnt1, 15);
        tick(); tick(); #1;
        chk("sat_hold", cnt1, 15);
        chk("sat_cnt2", cnt2, 17);
        idle_inputs();

        // Reset in cycle 2 of a multicycle op: abandoned, no completion pulse
        MCStart = 1'b1; #1;
        tick(); MCStart = 1'b0; #1;
        chk("mcr_c1", ctl1, C_BUSY);
        Reset = 1'b1; #1;
        chk("mcr_rst_ctl", ctl1, C_RST);
        chk("mcr_rst_cnt", cnt1, 0);
        tick(); Reset = 1'b0; #1;
        chk("mcr_post_ctl", ctl1, C_NORM);
        tick(); #1;
        chk("mcr_no_done", ctl1, C_NORM);
        chk("mcr_cnt", cnt1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
